led_code_scheduler: RTL and testbench
=====================================

Name: led_code_scheduler

Overview:
Shares one status LED between NUM_REQ requesters. Each requester posts a blink code, which is a count of pulses. A round-robin arbiter grants one code at a time. The sequencer plays the code as N on/off pulses followed by an inter-code gap, then releases the LED. The block sits between firmware/status sources and the board LED pin, alongside the free-running blinker.

Parameters:
FREQ_HZ, 100000000, clk frequency; all timing is derived as cycles = FREQ_HZ/1000 * ms
NUM_REQ, 4, number of requesters (2..8)
CNT_W, 4, width of each pulse-count field
ON_MS, 200, LED-on time per pulse
OFF_MS, 200, LED-off time between pulses of one code
GAP_MS, 1000, LED-off time after the last pulse of a code

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester code-valid
req_count  in  NUM_REQ*CNT_W  packed pulse counts; requester i occupies bits [i*CNT_W +: CNT_W]
req_ready  out  NUM_REQ  one-hot accept strobe (combinational)
done  out  NUM_REQ  one-cycle completion pulse for the granted requester
busy  out  1  high while a code is being played
active_id  out  $clog2(NUM_REQ)  index of the current or last granted requester
led  out  1  LED drive

Behaviour:
- Single clock domain (clk). Reset is asynchronous and active-high (reset).
- Reset values: state=IDLE, led=0, busy=0, done=0, active_id=0, timer=0, pulse counter=0, round-robin pointer=0 (requester 0 highest priority).
- Reset asserted mid-code aborts the code immediately. No done pulse is issued.
- Handshake:
  - A requester holds valid and count stable until it sees ready.
  - The transfer occurs on a cycle where req_valid[i] & req_ready[i].
  - req_ready is nonzero only in IDLE and is one-hot to the arbiter winner. It may depend combinationally on req_valid.
- Arbitration:
  - Round-robin. Search starts at the index after the last grant and wraps from NUM_REQ-1 to 0.
  - The pointer updates only on a grant.
  - If several requesters are valid in the same cycle, exactly one is granted.
- Timer: 32-bit down-counter. Phase lengths are ON_C, OFF_C and GAP_C. Each length is forced to a minimum of 1.
- State machine:
  - IDLE:
    - On grant, latch count and active_id and set busy=1.
    - If count>0, go to ON with timer=ON_C. If count==0, go to GAP with timer=GAP_C.
  - ON:
    - led=1.
    - When the timer expires, decrement remaining pulses.
    - If pulses remain, go to OFF (timer=OFF_C). Otherwise go to GAP (timer=GAP_C).
  - OFF: led=0. When the timer expires, go to ON.
  - GAP:
    - led=0.
    - On the final GAP cycle, done[active_id]=1 for exactly one cycle.
    - Next cycle go to IDLE with busy=0.
- Latency and timing:
  - led rises on the cycle after the grant cycle.
  - Each phase lasts exactly its cycle count.
  - Total busy duration = N*ON_C + (N-1)*OFF_C + GAP_C cycles.
- The LED is registered and glitch-free. led=0 in IDLE.
- Requests arriving while busy wait; they are not dropped.
- A requester may re-request in the cycle after its done pulse. The code is accepted only if the state is IDLE and the arbiter selects it.
- Maximum count: 2^CNT_W-1, with no wrap within a code.

Decomposition:
- Package led_sched_pkg:
  - state enum {IDLE, ON, OFF, GAP}
  - constant function ms_to_cycles(freq_hz, ms) with minimum-1 clamp
- Sub-module rr_arbiter (parameter N):
  - inputs: clk, reset, req[N], advance
  - outputs: grant one-hot and grant_idx
  - holds the round-robin pointer
- Top-level contains the FSM, timer and pulse counter.

Test Plan:
All scenarios use FREQ_HZ=1000, ON_MS=2, OFF_MS=3, GAP_MS=5, NUM_REQ=4, CNT_W=4, which gives 1 ms = 1 cycle.
- Single code: req0 count=3, grant at cycle 0 -> led=1 in cycles 1-2, 6-7, 11-12; led=0 in 3-5, 8-10, 13-17; done[0] in cycle 17; busy falls in cycle 18.
- Zero count: req2 count=0 -> ready[2] at cycle 0; led stays 0; done[2] at cycle 5; busy high for cycles 1-5.
- Contention: req0, req1 and req3 all valid at reset release with counts 1 each -> grant order 0, 1, 3, then 0 again if re-requested. req_ready stays one-hot throughout and no code is lost.
- Hold while busy: req1 asserts valid during req0's code -> req_ready[1] stays 0 until the cycle after busy falls; then ready[1]=1 and led rises on the next cycle.
- Mid-code reset: assert reset during the second ON phase of a count=3 code -> led, busy and done are 0 immediately (asynchronously); after release the state is IDLE and the pointer is at 0.
- Max count: count=15 -> exactly 15 rising edges of led, then a 5-cycle gap, and a single done pulse.

Source files
------------

// File: rtl/led_sched_pkg.sv
// Shared types and helpers for the LED blink-code scheduler.
//   state_t      : sequencer states (IDLE, ON, OFF, GAP)
//   ms_to_cycles : converts a millisecond duration into clock cycles,
//                  never returning less than one cycle so every phase is
//                  at least one clock long.
package led_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    GAP  = 2'd3
  } state_t;

  function automatic logic [31:0] ms_to_cycles(input longint unsigned freq_hz,
                                               input longint unsigned ms);
    longint unsigned c;
    c = (freq_hz / 64'd1000) * ms;
    if (c < 64'd1) c = 64'd1;
    // The phase timer is 32 bits wide; saturate rather than wrap.
    if (c > 64'd4294967295) c = 64'd4294967295;
    return c[31:0];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered priority pointer.
//   clk, reset : clock and asynchronous active-high reset
//   req        : per-requester request vector
//   advance    : accept the current winner; moves the pointer past it
//   grant      : one-hot winner (combinational, zero when no request)
//   grant_idx  : binary index of the winner
// The pointer names the highest-priority requester. After a grant it moves
// to the index just past the winner, wrapping from N-1 back to 0.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr;
  logic          found;
  int            idx;

  // Scan N positions starting at the pointer; the first active request wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found          = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/led_code_scheduler.sv
// Shares one status LED between NUM_REQ requesters, each posting a blink
// code (a pulse count). A round-robin arbiter picks one code at a time;
// the sequencer plays N on/off pulses, then a dark gap, then frees the LED.
//   clk, reset : clock and asynchronous active-high reset
//   req_valid  : per-requester code valid (held until req_ready)
//   req_count  : packed pulse counts, requester i at [i*CNT_W +: CNT_W]
//   req_ready  : one-hot accept strobe, only while idle (combinational)
//   done       : one-cycle pulse for the requester whose code just ended
//   busy       : high while a code is playing
//   active_id  : index of the current or most recently granted requester
//   led        : registered LED drive
module led_code_scheduler
  import led_sched_pkg::*;
#(
  parameter int FREQ_HZ = 100000000,
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 4,
  parameter int ON_MS   = 200,
  parameter int OFF_MS  = 200,
  parameter int GAP_MS  = 1000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*CNT_W-1:0]   req_count,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         done,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] active_id,
  output logic                       led
);

  localparam int          ID_W  = $clog2(NUM_REQ);
  localparam logic [31:0] ON_C  = ms_to_cycles(64'(FREQ_HZ), 64'(ON_MS));
  localparam logic [31:0] OFF_C = ms_to_cycles(64'(FREQ_HZ), 64'(OFF_MS));
  localparam logic [31:0] GAP_C = ms_to_cycles(64'(FREQ_HZ), 64'(GAP_MS));

  state_t            state, state_nxt;
  logic [31:0]       timer, timer_nxt;
  logic [CNT_W-1:0]  pulses, pulses_nxt;
  logic              busy_nxt;
  logic              led_nxt;
  logic [ID_W-1:0]   active_nxt;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic [CNT_W-1:0]   grant_count;
  logic               in_idle;
  logic               take;
  logic               expire;

  assign in_idle = (state == IDLE);
  assign take    = in_idle && (|req_valid);
  // Timer holds the cycles left in the current phase, including this one.
  assign expire  = (timer == 32'd1);

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req_valid),
    .advance   (take),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready   = in_idle ? grant : '0;
  assign grant_count = req_count[int'(grant_idx)*CNT_W +: CNT_W];

  // done is decoded from registered state, so it cannot glitch and drops
  // immediately when reset forces the state back to IDLE.
  assign done = (state == GAP && expire) ? (NUM_REQ'(1) << active_id) : '0;

  always_comb begin
    state_nxt  = state;
    timer_nxt  = timer;
    pulses_nxt = pulses;
    busy_nxt   = busy;
    active_nxt = active_id;
    case (state)
      IDLE: begin
        if (take) begin
          active_nxt = grant_idx;
          busy_nxt   = 1'b1;
          if (grant_count != '0) begin
            state_nxt  = ON;
            timer_nxt  = ON_C;
            pulses_nxt = grant_count;
          end else begin
            state_nxt  = GAP;
            timer_nxt  = GAP_C;
            pulses_nxt = '0;
          end
        end
      end
      ON: begin
        if (expire) begin
          pulses_nxt = pulses - 1'b1;
          if (pulses > CNT_W'(1)) begin
            state_nxt = OFF;
            timer_nxt = OFF_C;
          end else begin
            state_nxt = GAP;
            timer_nxt = GAP_C;
          end
        end else begin
          timer_nxt = timer - 32'd1;
        end
      end
      OFF: begin
        if (expire) begin
          state_nxt = ON;
          timer_nxt = ON_C;
        end else begin
          timer_nxt = timer - 32'd1;
        end
      end
      GAP: begin
        if (expire) begin
          state_nxt = IDLE;
          timer_nxt = '0;
          busy_nxt  = 1'b0;
        end else begin
          timer_nxt = timer - 32'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        timer_nxt = '0;
        busy_nxt  = 1'b0;
      end
    endcase
    // LED register follows the next state, so it lights on the cycle
    // after the grant and tracks each phase exactly.
    led_nxt = (state_nxt == ON);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      pulses    <= '0;
      busy      <= 1'b0;
      led       <= 1'b0;
      active_id <= '0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      pulses    <= pulses_nxt;
      busy      <= busy_nxt;
      led       <= led_nxt;
      active_id <= active_nxt;
    end
  end

endmodule

// File: tb/tb_led_code_scheduler.sv
// Directed bench for led_code_scheduler with 1 ms = 1 cycle timing
// (ON=2, OFF=3, GAP=5 cycles). Cycle 0 is the grant cycle of a code.
module tb_led_code_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [15:0] req_count;
  logic [3:0]  req_ready;
  logic [3:0]  done;
  logic        busy;
  logic [1:0]  active_id;
  logic        led;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  led_code_scheduler #(
    .FREQ_HZ (1000),
    .NUM_REQ (4),
    .CNT_W   (4),
    .ON_MS   (2),
    .OFF_MS  (3),
    .GAP_MS  (5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_count (req_count),
    .req_ready (req_ready),
    .done      (done),
    .busy      (busy),
    .active_id (active_id),
    .led       (led)
  );

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Leaves the bench just after a falling edge with reset released.
  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    req_count = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Raises a request just after a rising edge; the following falling
  // edge is cycle 0 of that request.
  task automatic post(input int id, input int cnt);
    logic [3:0] c4;
    c4 = cnt[3:0];
    @(posedge clk);
    #1;
    req_valid[id]         = 1'b1;
    req_count[id*4 +: 4]  = c4;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int         e_led, e_busy, e_done;
    int         order[$];
    int         ndone[4];
    int         total_done, widx, rising, last_on, done_c, busy_cyc;
    logic [3:0] rdy, dn, done_val;
    logic       prev_led, rereq, finished;

    // ---------------- reset state ----------------
    reset     = 1'b1;
    req_valid = '0;
    req_count = '0;
    @(negedge clk);
    check_val("rst_led",    32'(led),       0);
    check_val("rst_busy",   32'(busy),      0);
    check_val("rst_done",   32'(done),      0);
    check_val("rst_active", 32'(active_id), 0);
    check_val("rst_ready",  32'(req_ready), 0);
    do_reset();

    // ---------------- single code: req0 count 3 ----------------
    post(0, 3);
    @(negedge clk);
    check_val("s1_ready_c0", 32'(req_ready), 1);
    @(posedge clk); #1; req_valid[0] = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      e_led  = ((c >= 1 && c <= 2) || (c >= 6 && c <= 7) ||
                (c >= 11 && c <= 12)) ? 1 : 0;
      e_busy = (c <= 17) ? 1 : 0;
      e_done = (c == 17) ? 1 : 0;
      check_val($sformatf("s1_led_c%0d", c),  32'(led),  32'(e_led));
      check_val($sformatf("s1_busy_c%0d", c), 32'(busy), 32'(e_busy));
      check_val($sformatf("s1_done_c%0d", c), 32'(done), 32'(e_done));
      if (c == 1) check_val("s1_active", 32'(active_id), 0);
    end

    // ---------------- zero count: req2 ----------------
    post(2, 0);
    @(negedge clk);
    check_val("s2_ready_c0", 32'(req_ready), 4);
    @(posedge clk); #1; req_valid[2] = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      e_busy = (c <= 5) ? 1 : 0;
      e_done = (c == 5) ? 4 : 0;
      check_val($sformatf("s2_led_c%0d", c),  32'(led),  0);
      check_val($sformatf("s2_busy_c%0d", c), 32'(busy), 32'(e_busy));
      check_val($sformatf("s2_done_c%0d", c), 32'(done), 32'(e_done));
    end
    check_val("s2_active", 32'(active_id), 2);

    // ---------------- contention: 0,1,3 at reset release ----------------
    do_reset();
    @(posedge clk); #1;
    req_valid = 4'b1011;
    req_count = 16'h1011;
    ndone     = '{0, 0, 0, 0};
    total_done = 0;
    rereq     = 1'b0;
    finished  = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      rdy = req_ready;
      dn  = done;
      check_val("cont_onehot", 32'($countones(rdy) <= 1), 1);
      if (rdy != 4'b0000) begin
        check_val("cont_ready_idle", 32'(busy), 0);
        widx = -1;
        for (int i = 0; i < 4; i++) if (rdy[i]) widx = i;
        order.push_back(widx);
      end
      for (int i = 0; i < 4; i++) if (dn[i]) begin
        ndone[i]++;
        total_done++;
      end
      if (total_done == 4) begin
        finished = 1'b1;
        break;
      end
      @(posedge clk); #1;
      req_valid = req_valid & ~rdy;
      if (dn[0] && !rereq) begin
        req_valid[0] = 1'b1;
        rereq        = 1'b1;
      end
    end
    check_val("cont_finished", 32'(finished), 1);
    while (order.size() < 4) order.push_back(-1);
    check_val("cont_grants",  32'(order.size()), 4);
    check_val("cont_order0",  32'(order[0]), 0);
    check_val("cont_order1",  32'(order[1]), 1);
    check_val("cont_order2",  32'(order[2]), 3);
    check_val("cont_order3",  32'(order[3]), 0);
    check_val("cont_done0",   32'(ndone[0]), 2);
    check_val("cont_done1",   32'(ndone[1]), 1);
    check_val("cont_done2",   32'(ndone[2]), 0);
    check_val("cont_done3",   32'(ndone[3]), 1);

    // ---------------- hold while busy ----------------
    do_reset();
    post(0, 2);
    @(negedge clk);
    check_val("hb_ready_c0", 32'(req_ready), 1);
    @(posedge clk); #1; req_valid[0] = 1'b0;
    // count 2: busy for 2*2 + 3 + 5 = 12 cycles
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      check_val($sformatf("hb_busy_c%0d", c),  32'(busy),      1);
      check_val($sformatf("hb_ready_c%0d", c), 32'(req_ready), 0);
      if (c == 2) begin
        req_valid[1]      = 1'b1;
        req_count[7:4]    = 4'd3;
      end
    end
    @(negedge clk);
    check_val("hb_busy_c13",  32'(busy),      0);
    check_val("hb_ready_c13", 32'(req_ready), 2);
    @(posedge clk); #1; req_valid[1] = 1'b0;
    @(negedge clk);
    check_val("hb_led_c14",    32'(led),       1);
    check_val("hb_active_c14", 32'(active_id), 1);
    finished = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!busy) begin
        finished = 1'b1;
        break;
      end
    end
    check_val("hb_idle_again", 32'(finished), 1);

    // ---------------- mid-code reset ----------------
    do_reset();
    post(0, 3);
    @(negedge clk);
    check_val("mr_ready_c0", 32'(req_ready), 1);
    @(posedge clk); #1; req_valid[0] = 1'b0;
    repeat (6) @(negedge clk);
    check_val("mr_led_on_c6", 32'(led), 1);
    #1;
    reset = 1'b1;
    #1;
    check_val("mr_led_async",  32'(led),  0);
    check_val("mr_busy_async", 32'(busy), 0);
    check_val("mr_done_async", 32'(done), 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_val("mr_busy_after",   32'(busy),      0);
    check_val("mr_led_after",    32'(led),       0);
    check_val("mr_active_after", 32'(active_id), 0);
    #1;
    req_valid = 4'b0011;
    req_count = 16'h0011;
    #1;
    check_val("mr_ptr_zero", 32'(req_ready), 1);
    req_valid = '0;
    @(negedge clk);
    check_val("mr_still_idle", 32'(busy), 0);

    // ---------------- max count: req3 count 15 ----------------
    do_reset();
    post(3, 15);
    @(negedge clk);
    check_val("mx_ready_c0", 32'(req_ready), 8);
    @(posedge clk); #1; req_valid[3] = 1'b0;
    rising   = 0;
    last_on  = -100;
    done_c   = -1;
    busy_cyc = 0;
    total_done = 0;
    done_val = '0;
    prev_led = 1'b0;
    finished = 1'b0;
    for (int c = 1; c <= 150; c++) begin
      @(negedge clk);
      if (led && !prev_led) rising++;
      if (led) last_on = c;
      if (done != 4'b0000) begin
        total_done++;
        done_c   = c;
        done_val = done;
      end
      if (busy) busy_cyc++;
      prev_led = led;
      if (!busy) begin
        finished = 1'b1;
        break;
      end
    end
    check_val("mx_finished",  32'(finished),        1);
    check_val("mx_rising",    32'(rising),          15);
    check_val("mx_busy_cyc",  32'(busy_cyc),        77);
    check_val("mx_done_cnt",  32'(total_done),      1);
    check_val("mx_done_val",  32'(done_val),        8);
    check_val("mx_done_cyc",  32'(done_c),          77);
    check_val("mx_gap_len",   32'(done_c - last_on), 5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
